// File: rtl/rv32_clint.sv
// rv32_clint: single-hart core-local interruptor (mtime, mtimecmp, msip) behind an
// AXI4-Lite responder. AW and W are only accepted together; reads and writes run independently.
module rv32_clint #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int TICK_DIV = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [ADDR_W-1:0]   s_awaddr_i,
  input  logic                s_awvalid_i,
  output logic                s_awready_o,
  input  logic [DATA_W-1:0]   s_wdata_i,
  input  logic [DATA_W/8-1:0] s_wstrb_i,
  input  logic                s_wvalid_i,
  output logic                s_wready_o,
  output logic [1:0]          s_bresp_o,
  output logic                s_bvalid_o,
  input  logic                s_bready_i,
  input  logic [ADDR_W-1:0]   s_araddr_i,
  input  logic                s_arvalid_i,
  output logic                s_arready_o,
  output logic [DATA_W-1:0]   s_rdata_o,
  output logic [1:0]          s_rresp_o,
  output logic                s_rvalid_o,
  input  logic                s_rready_i,
  output logic                irq_timer_o,
  output logic                irq_soft_o,
  output logic [63:0]         mtime_o
);
  localparam int NB = DATA_W / 8;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // Word indices (addr[15:2]) of the mapped registers
  localparam logic [13:0] IDX_MSIP    = 14'h0000;
  localparam logic [13:0] IDX_CMP_LO  = 14'h1000;
  localparam logic [13:0] IDX_CMP_HI  = 14'h1001;
  localparam logic [13:0] IDX_TIME_LO = 14'h2FFE;
  localparam logic [13:0] IDX_TIME_HI = 14'h2FFF;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  w_state_e          w_state, w_state_nxt;
  r_state_e          r_state, r_state_nxt;
  logic [63:0]       mtime, mtimecmp;
  logic              msip;
  logic [PW-1:0]     presc;
  logic              tick, w_fire, r_fire, w_map, r_map;
  logic [13:0]       w_idx, r_idx;
  logic [DATA_W-1:0] wmask, w_old, w_new, r_val;
  logic              unused_addr;

  assign w_idx       = s_awaddr_i[15:2];
  assign r_idx       = s_araddr_i[15:2];
  assign unused_addr = ^{s_awaddr_i[1:0], s_araddr_i[1:0]};
  assign tick        = (presc == PW'(TICK_DIV - 1));

  for (genvar b = 0; b < NB; b++) begin : g_mask
    assign wmask[b*8 +: 8] = {8{s_wstrb_i[b]}};
  end

  // Old word of the addressed register, merged with the strobed bus bytes
  always_comb begin
    w_map = 1'b1;
    case (w_idx)
      IDX_MSIP:    w_old = {31'b0, msip};
      IDX_CMP_LO:  w_old = mtimecmp[31:0];
      IDX_CMP_HI:  w_old = mtimecmp[63:32];
      IDX_TIME_LO: w_old = mtime[31:0];
      IDX_TIME_HI: w_old = mtime[63:32];
      default: begin
        w_old = '0;
        w_map = 1'b0;
      end
    endcase
  end
  assign w_new = (w_old & ~wmask) | (s_wdata_i & wmask);

  always_comb begin
    r_map = 1'b1;
    case (r_idx)
      IDX_MSIP:    r_val = {31'b0, msip};
      IDX_CMP_LO:  r_val = mtimecmp[31:0];
      IDX_CMP_HI:  r_val = mtimecmp[63:32];
      IDX_TIME_LO: r_val = mtime[31:0];
      IDX_TIME_HI: r_val = mtime[63:32];
      default: begin
        r_val = '0;
        r_map = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_state_nxt = w_state;
    r_state_nxt = r_state;
    w_fire      = 1'b0;
    r_fire      = 1'b0;
    case (w_state)
      W_IDLE: begin
        w_fire = s_awvalid_i & s_wvalid_i;
        if (w_fire) w_state_nxt = W_RESP;
      end
      default: if (s_bready_i) w_state_nxt = W_IDLE;
    endcase
    case (r_state)
      R_IDLE: begin
        r_fire = s_arvalid_i;
        if (r_fire) r_state_nxt = R_DATA;
      end
      default: if (s_rready_i) r_state_nxt = R_IDLE;
    endcase
  end

  assign s_awready_o = w_fire;
  assign s_wready_o  = w_fire;
  assign s_bvalid_o  = (w_state == W_RESP);
  assign s_arready_o = (r_state == R_IDLE);
  assign s_rvalid_o  = (r_state == R_DATA);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state   <= W_IDLE;
      r_state   <= R_IDLE;
      s_bresp_o <= 2'b00;
      s_rresp_o <= 2'b00;
      s_rdata_o <= '0;
    end else begin
      w_state <= w_state_nxt;
      r_state <= r_state_nxt;
      if (w_fire) s_bresp_o <= w_map ? 2'b00 : 2'b10;
      if (r_fire) begin
        s_rdata_o <= r_val;
        s_rresp_o <= r_map ? 2'b00 : 2'b10;
      end
    end
  end

  // A bus write to either mtime half takes precedence over the tick increment
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc       <= '0;
      mtime       <= '0;
      mtimecmp    <= '1;
      msip        <= 1'b0;
      irq_timer_o <= 1'b0;
    end else begin
      presc       <= tick ? '0 : presc + 1'b1;
      irq_timer_o <= (mtime >= mtimecmp);
      if (w_fire && w_idx == IDX_TIME_LO)      mtime[31:0]  <= w_new;
      else if (w_fire && w_idx == IDX_TIME_HI) mtime[63:32] <= w_new;
      else if (tick)                           mtime        <= mtime + 64'd1;
      if (w_fire && w_idx == IDX_CMP_LO) mtimecmp[31:0]  <= w_new;
      if (w_fire && w_idx == IDX_CMP_HI) mtimecmp[63:32] <= w_new;
      if (w_fire && w_idx == IDX_MSIP)   msip            <= w_new[0];
    end
  end

  assign irq_soft_o = msip;
  assign mtime_o    = mtime;
endmodule

// File: tb/tb_rv32_clint.sv
// Self-checking bench for rv32_clint: vector table, directed corner sequences and random traffic
// checked every cycle against a transaction-level model (TICK_DIV=1 and TICK_DIV=4 instances).
module tb_rv32_clint;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] awaddr = '0, araddr = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;

  logic        awready, wready, bvalid, arready, rvalid, irq_timer, irq_soft;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [63:0] mtime;
  logic        awready4, wready4, bvalid4, arready4, rvalid4, irq_timer4, irq_soft4;
  logic [1:0]  bresp4, rresp4;
  logic [31:0] rdata4;
  logic [63:0] mtime4;

  int errs = 0, checks = 0;
  logic chk_en = 1'b0, rand_bp = 1'b0;

  always #5 clk = ~clk;

  rv32_clint #(.ADDR_W(16), .DATA_W(32), .TICK_DIV(1)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .s_awaddr_i(awaddr), .s_awvalid_i(awvalid), .s_awready_o(awready),
    .s_wdata_i(wdata), .s_wstrb_i(wstrb), .s_wvalid_i(wvalid), .s_wready_o(wready),
    .s_bresp_o(bresp), .s_bvalid_o(bvalid), .s_bready_i(bready),
    .s_araddr_i(araddr), .s_arvalid_i(arvalid), .s_arready_o(arready),
    .s_rdata_o(rdata), .s_rresp_o(rresp), .s_rvalid_o(rvalid), .s_rready_i(rready),
    .irq_timer_o(irq_timer), .irq_soft_o(irq_soft), .mtime_o(mtime));

  rv32_clint #(.ADDR_W(16), .DATA_W(32), .TICK_DIV(4)) u_div4 (
    .clk_i(clk), .rst_i(rst),
    .s_awaddr_i(awaddr), .s_awvalid_i(awvalid), .s_awready_o(awready4),
    .s_wdata_i(wdata), .s_wstrb_i(wstrb), .s_wvalid_i(wvalid), .s_wready_o(wready4),
    .s_bresp_o(bresp4), .s_bvalid_o(bvalid4), .s_bready_i(bready),
    .s_araddr_i(araddr), .s_arvalid_i(arvalid), .s_arready_o(arready4),
    .s_rdata_o(rdata4), .s_rresp_o(rresp4), .s_rvalid_o(rvalid4), .s_rready_i(rready),
    .irq_timer_o(irq_timer4), .irq_soft_o(irq_soft4), .mtime_o(mtime4));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errs++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [63:0] m_t1, m_t4, m_cmp;
  logic        m_msip, m_irq1, m_irq4, m_wbusy, m_rbusy, m_twr, m_wr, m_rd;
  logic [1:0]  m_bresp, m_rresp;
  logic [31:0] m_rdata;
  logic [32:0] m_rv;
  int unsigned m_cyc;

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  // bit 32 = mapped
  function automatic logic [32:0] reg_read(input logic [15:0] a, input logic [63:0] t,
                                           input logic [63:0] cmp, input logic ms);
    case (a & 16'hFFFC)
      16'h0000: return {1'b1, 31'b0, ms};
      16'h4000: return {1'b1, cmp[31:0]};
      16'h4004: return {1'b1, cmp[63:32]};
      16'hBFF8: return {1'b1, t[31:0]};
      16'hBFFC: return {1'b1, t[63:32]};
      default:  return 33'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_t1 = '0; m_t4 = '0; m_cmp = '1; m_msip = 1'b0; m_irq1 = 1'b0; m_irq4 = 1'b0;
      m_wbusy = 1'b0; m_rbusy = 1'b0; m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = '0; m_cyc = 0;
    end else begin
      m_wr   = !m_wbusy && awvalid && wvalid;
      m_rd   = !m_rbusy && arvalid;
      m_irq1 = (m_t1 >= m_cmp);
      m_irq4 = (m_t4 >= m_cmp);
      if (m_rd) begin
        m_rv    = reg_read(araddr, m_t1, m_cmp, m_msip);
        m_rdata = m_rv[31:0];
        m_rresp = m_rv[32] ? 2'b00 : 2'b10;
        m_rbusy = 1'b1;
      end else if (m_rbusy && rready) m_rbusy = 1'b0;
      m_cyc++;
      m_twr = 1'b0;
      if (m_wr) begin
        m_bresp = 2'b00;
        case (awaddr & 16'hFFFC)
          16'h0000: if (wstrb[0]) m_msip = wdata[0];
          16'h4000: m_cmp[31:0]  = bmerge(m_cmp[31:0], wdata, wstrb);
          16'h4004: m_cmp[63:32] = bmerge(m_cmp[63:32], wdata, wstrb);
          16'hBFF8: begin
            m_t1[31:0] = bmerge(m_t1[31:0], wdata, wstrb);
            m_t4[31:0] = bmerge(m_t4[31:0], wdata, wstrb);
            m_twr = 1'b1;
          end
          16'hBFFC: begin
            m_t1[63:32] = bmerge(m_t1[63:32], wdata, wstrb);
            m_t4[63:32] = bmerge(m_t4[63:32], wdata, wstrb);
            m_twr = 1'b1;
          end
          default: m_bresp = 2'b10;
        endcase
        m_wbusy = 1'b1;
      end else if (m_wbusy && bready) m_wbusy = 1'b0;
      if (!m_twr) begin
        m_t1 = m_t1 + 64'd1;
        if (m_cyc % 4 == 0) m_t4 = m_t4 + 64'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mtime", mtime, m_t1);
      chk("mtime_div4", mtime4, m_t4);
      chk("irq_timer", 64'(irq_timer), 64'(m_irq1));
      chk("irq_timer_div4", 64'(irq_timer4), 64'(m_irq4));
      chk("irq_soft", 64'(irq_soft), 64'(m_msip));
      chk("bvalid", 64'(bvalid), 64'(m_wbusy));
      chk("rvalid", 64'(rvalid), 64'(m_rbusy));
      chk("arready", 64'(arready), 64'(!m_rbusy));
      if (m_wbusy) chk("bresp", 64'(bresp), 64'(m_bresp));
      if (m_rbusy) begin
        chk("rdata", 64'(rdata), 64'(m_rdata));
        chk("rresp", 64'(rresp), 64'(m_rresp));
      end
    end
  end

  always @(negedge clk) if (rand_bp) bready = 1'($urandom_range(0, 1));

  // ---------------- bus tasks ----------------
  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] br);
    int n;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) timeout("write_handshake");
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    br = bresp;
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] d, output logic [1:0] r);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    #1;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) timeout("read_handshake");
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeout("read_data");
    d = rdata; r = rresp;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [1:0]  eb;
    logic [31:0] er;
    logic [1:0]  err;
  } vec_t;
  vec_t tbl[11];

  logic [31:0] d, d0, rv;
  logic [1:0]  br, r;
  logic [15:0] ra;
  int n;
  logic found;
  logic [15:0] addrs[9] = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC,
                            16'h1000, 16'h0004, 16'h4008, 16'hFFFC};

  initial begin
    tbl[0]  = '{16'h0000, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'h0000_0001, 2'b00};
    tbl[1]  = '{16'h0000, 32'h0000_0000, 4'hF, 2'b00, 32'h0000_0000, 2'b00};
    tbl[2]  = '{16'h4000, 32'h1122_3344, 4'hF, 2'b00, 32'h1122_3344, 2'b00};
    tbl[3]  = '{16'h4000, 32'hAABB_CCDD, 4'b0100, 2'b00, 32'h11BB_3344, 2'b00};
    tbl[4]  = '{16'h4004, 32'h5566_7788, 4'b1001, 2'b00, 32'h55FF_FF88, 2'b00};
    tbl[5]  = '{16'h4003, 32'h0000_0000, 4'b0011, 2'b00, 32'h11BB_0000, 2'b00};
    tbl[6]  = '{16'h1000, 32'hDEAD_BEEF, 4'hF, 2'b10, 32'h0000_0000, 2'b10};
    tbl[7]  = '{16'h0008, 32'h0000_0001, 4'hF, 2'b10, 32'h0000_0000, 2'b10};
    tbl[8]  = '{16'h0001, 32'h0000_0001, 4'b0000, 2'b00, 32'h0000_0000, 2'b00};
    tbl[9]  = '{16'h0002, 32'h0000_0003, 4'b0001, 2'b00, 32'h0000_0001, 2'b00};
    tbl[10] = '{16'h0000, 32'h0000_0000, 4'hF, 2'b00, 32'h0000_0000, 2'b00};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_mtime", mtime, 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_bresp", 64'(bresp), 64'd0);
    chk("rst_rresp", 64'(rresp), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_irq_timer", 64'(irq_timer), 64'd0);
    chk("rst_irq_soft", 64'(irq_soft), 64'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    rd(16'h4000, d, r); chk("rst_cmp_lo", 64'(d), 64'hFFFF_FFFF); chk("rst_cmp_lo_resp", 64'(r), 64'd0);
    rd(16'h4004, d, r); chk("rst_cmp_hi", 64'(d), 64'hFFFF_FFFF); chk("rst_cmp_hi_resp", 64'(r), 64'd0);
    rd(16'hBFF8, d, r); chk("rst_mtime_small", 64'(d < 32'd64), 64'd1);

    // register access table
    for (int i = 0; i < 11; i++) begin
      wr(tbl[i].a, tbl[i].d, tbl[i].s, br);
      chk($sformatf("tbl%0d_bresp", i), 64'(br), 64'(tbl[i].eb));
      rd(tbl[i].a, d, r);
      chk($sformatf("tbl%0d_rdata", i), 64'(d), 64'(tbl[i].er));
      chk($sformatf("tbl%0d_rresp", i), 64'(r), 64'(tbl[i].err));
    end

    // timer compare: rise one cycle after mtime==20, fall two cycles after raising mtimecmp
    wr(16'hBFF8, 32'd0, 4'hF, br);
    wr(16'hBFFC, 32'd0, 4'hF, br);
    wr(16'h4000, 32'd20, 4'hF, br);
    wr(16'h4004, 32'd0, 4'hF, br);
    n = 0;
    while (mtime != 64'd20 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) timeout("mtime_reach_20");
    chk("t2_irq_at_20", 64'(irq_timer), 64'd0);
    @(negedge clk);
    chk("t2_irq_rise", 64'(irq_timer), 64'd1);
    wr(16'h4000, 32'hFFFF_FFFF, 4'hF, br);
    chk("t2_irq_hs_plus1", 64'(irq_timer), 64'd1);
    @(negedge clk);
    chk("t2_irq_fall", 64'(irq_timer), 64'd0);

    // software interrupt
    wr(16'h0000, 32'd1, 4'hF, br);
    chk("msip_set", 64'(irq_soft), 64'd1);
    wr(16'h0000, 32'd0, 4'hF, br);
    chk("msip_clr", 64'(irq_soft), 64'd0);
    wr(16'h0000, 32'hFFFF_FFFF, 4'hF, br);
    rd(16'h0000, d, r);
    chk("msip_raz", 64'(d), 64'd1);
    wr(16'h0000, 32'd0, 4'hF, br);

    // errors and read backpressure
    wr(16'h1000, 32'h1234_5678, 4'hF, br);
    chk("unmapped_bresp", 64'(br), 64'h2);
    rd(16'h4000, d, r);
    chk("unmapped_nochange", 64'(d), 64'hFFFF_FFFF);
    rd(16'h2000, d, r);
    chk("unmapped_rdata", 64'(d), 64'd0);
    chk("unmapped_rresp", 64'(r), 64'h2);
    @(negedge clk);
    araddr = 16'h4004; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    d0 = rdata;
    chk("bp_first", 64'(d0), 64'd0);
    repeat (5) begin
      @(negedge clk);
      chk("bp_rvalid", 64'(rvalid), 64'd1);
      chk("bp_rdata", 64'(rdata), 64'(d0));
      chk("bp_arready", 64'(arready), 64'd0);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk("bp_release", 64'(rvalid), 64'd0);

    // 64-bit wrap with TICK_DIV=4
    wr(16'hBFFC, 32'hFFFF_FFFF, 4'hF, br);
    wr(16'hBFF8, 32'hFFFF_FFFE, 4'hF, br);
    chk("wrap_start_div4", mtime4, 64'hFFFF_FFFF_FFFF_FFFE);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (mtime4 == 64'd0) found = 1'b1;
    end
    chk("wrap_div4_within_8", 64'(found), 64'd1);

    // reset while a write response is pending
    bready = 1'b0;
    wr(16'h4000, 32'h0000_1234, 4'hF, br);
    chk("rstmid_bvalid_before", 64'(bvalid), 64'd1);
    @(negedge clk);
    chk("rstmid_bvalid_held", 64'(bvalid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_bvalid", 64'(bvalid), 64'd0);
    chk("rstmid_mtime", mtime, 64'd0);
    rst = 1'b0;
    bready = 1'b1;
    rd(16'h4000, d, r);
    chk("rstmid_cmp", 64'(d), 64'hFFFF_FFFF);

    // random traffic against the model
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ra = addrs[$urandom_range(0, 8)];
      rv = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 40));
      case ($urandom_range(0, 2))
        0: wr(addrs[$urandom_range(0, 8)], rv, 4'($urandom_range(0, 15)), br);
        1: rd(ra, d, r);
        default: fork
          wr(addrs[$urandom_range(0, 8)], rv, 4'($urandom_range(0, 15)), br);
          rd(ra, d0, r);
        join
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    rand_bp = 1'b0;
    bready = 1'b1;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
